rv32_fetch_unit: RTL

Instruction fetch stage for the RV32I multi-cycle datapath. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and holds each fetched instruction stable on `o_instruction` for the controller and decode logic until the datapath consumes it. On consumption it selects the next PC from the controller's `PCSel` decision: PC+4 or the ALU-computed jump/branch target.

---
 rtl/rv32_fetch_unit.sv | 78 +++++++
 1 files changed

// File: rtl/rv32_fetch_unit.sv
// RV32I multi-cycle fetch stage: owns the PC, fetches one word at a time over
// a req/ack handshake and holds the instruction until the datapath consumes it.
module rv32_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_misaligned,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      o_instruction <= 32'h0000_0013;
      o_valid       <= 1'b0;
      o_imem_req    <= 1'b0;
      o_misaligned  <= 1'b0;
      o_fetch_count <= '0;
    end else begin
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          state      <= FETCH;
          pc         <= RESET_PC;
          o_imem_req <= 1'b1;
        end
        FETCH: begin
          if (i_imem_ack) begin
            o_instruction <= i_imem_rdata;
            o_valid       <= 1'b1;
            o_imem_req    <= 1'b0;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (i_ready) begin
            // The PC register doubles as the next fetch address, so the
            // request and new address appear together on the following cycle.
            pc            <= i_pc_sel ? {i_alu_target[31:2], 2'b00} : pc + 32'd4;
            o_misaligned  <= i_pc_sel & (|i_alu_target[1:0]);
            o_fetch_count <= o_fetch_count + 32'd1;
            o_valid       <= 1'b0;
            o_imem_req    <= 1'b1;
            state         <= FETCH;
          end
        end
        default: begin
          state      <= IDLE;
          o_valid    <= 1'b0;
          o_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc        = pc;
  assign o_imem_addr = pc;
  assign o_pc_plus4  = pc + 32'd4;

endmodule
